mul_ctrl: RTL and testbench
===========================

# mul_ctrl

Sequencing controller between the EX stage and the one-cycle `mul_alu` multiplier. It:
- decodes multiply-class instructions;
- drives the multiplier's start/operand/sign inputs;
- owns the architectural HI/LO registers, including MADD/MSUB accumulation;
- stalls the pipeline until each operation retires.

A pipeline flush aborts any in-flight operation without touching HI/LO.

## Interface
- Parameters: none.
- Shared constants come from `mul_ctrl_pkg`.

Ports:
- `cpu_clk` in 1: clock.
- `cpu_rst` in 1: asynchronous, active-high reset.
- `ex_valid` in 1: EX stage presents an instruction this cycle.
- `ex_op` in 4: operation code; `MUL_NOP`, `MULT`, `MULTU`, `MUL`, `MADD`, `MADDU`, `MSUB`, `MSUBU`, `MTHI`, `MTLO`.
- `ex_src1` in 32: rs operand.
- `ex_src2` in 32: rt operand.
- `flush` in 1: pipeline flush; abort the current operation.
- `ex_stall` out 1: hold EX stage.
- `res_valid` out 1: `MUL` GPR result valid this cycle.
- `res_data` out 32: `MUL` result, the low 32 bits of the product.
- `hi` out 32: HI register.
- `lo` out 32: LO register.
- `mul_start` out 1: multiplier start.
- `mul_reg1` out 32: multiplier operand 1.
- `mul_reg2` out 32: multiplier operand 2.
- `mul_signed` out 1: multiplier `signed_op`.
- `mul_done` in 1: multiplier done.
- `mul_result` in 64: multiplier product.

## Operation
- FSM states:
  - `IDLE`: accept only if `ex_valid && !flush`; multiply-class op latches src1/src2, sign and op, then goes to `ISSUE`. `MTHI`/`MTLO` write `hi`/`lo` at this edge, no stall, stay in `IDLE`. `MUL_NOP` does nothing.
  - `ISSUE`: `mul_start`=1 for exactly this cycle, then `WAIT`.
  - `WAIT`: on `mul_done`:
    - `MULT`/`MULTU` write {hi,lo}=`mul_result`, go to `IDLE`.
    - `MUL` pulses `res_valid` with `res_data`=`mul_result[31:0]`, leaves HI/LO unchanged, goes to `IDLE`.
    - MADD family latches the product and goes to `ACC`.
  - `ACC`: {hi,lo} = {hi,lo} ± product, 64-bit wrap-around arithmetic, then `IDLE`.
- `mul_signed`=1 for `MULT`, `MUL`, `MADD`, `MSUB`; 0 otherwise. The accumulate add/subtract itself is sign-agnostic (64-bit modular).
- `mul_reg1`/`mul_reg2`/`mul_signed` are registers. They are loaded on accept and hold until the next accept.
- `ex_stall` is combinational:
  - 1 in the `IDLE` accept cycle of a multiply-class op, in `ISSUE`, and in `WAIT` for MADD-family ops or while `mul_done`=0.
  - 0 in the final cycle (`WAIT`+`mul_done` for MULT/MULTU/MUL; `ACC` for MADD family).
  - The EX stage advances at the end of the final cycle, so the same instruction is never re-accepted.
- `flush`:
  - Highest priority in every state: next state is `IDLE`, no HI/LO write, `res_valid`=0, `ex_stall`=0 in that cycle.
  - A `mul_done` arriving in `IDLE` after a flush is ignored.
  - `flush` with `ex_valid` in `IDLE`: not accepted.
- `MFHI`/`MFLO` read `hi`/`lo` directly. A write is visible the cycle after its edge.
- Reset values:
  - state `IDLE`; `hi`=`lo`=0; `mul_start`=0; `mul_reg1`=`mul_reg2`=0; `mul_signed`=0.
  - Combinational outputs `ex_stall`/`res_valid`/`res_data` are 0 while `cpu_rst`=1.
  - Reset mid-operation discards the operation.

## Timing
- Accept at cycle c0.
- `mul_start`=1 at c1; multiplier `done` at c2.
- MULT/MULTU: HI/LO written at end of c2, visible c3; `ex_stall`=1 in c0–c1.
- MUL: `res_valid` in c2; `ex_stall`=1 in c0–c1.
- MADD family: `ACC` in c3, HI/LO visible c4; `ex_stall`=1 in c0–c2.
- MTHI/MTLO: zero stall; value visible c1.
- Back-to-back multiply ops: the next op is accepted in the cycle after the final cycle.

## Structure
- `mul_ctrl_pkg`: `ex_op` encodings (4-bit), FSM state enum, and `is_mul_class`/`is_signed`/`is_acc`/`is_sub` decode helpers.
- Sub-module `mul_hilo`: HI/LO register pair with write-product, write-single (MTHI/MTLO) and accumulate add/sub ports, async reset.
- `mul_alu` is instantiated beside `mul_ctrl` by the parent, not inside it.

## Test plan
1. MULT, src1=0xFFFFFFFE, src2=3 -> `mul_start` in c1, `ex_stall`=1 in c0–c1 only, c3 `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
2. MULTU, same operands -> c3 `hi`=0x00000002, `lo`=0xFFFFFFFA, `mul_signed`=0.
3. MUL, 7×6 with hi/lo=0x11/0x22 -> `res_valid`=1, `res_data`=0x2A in c2; hi/lo unchanged.
4. MADD, hi=0, lo=0xFFFFFFFF, 1×1 -> c4 hi=1, lo=0. MSUBU from hi=lo=0, 1×1 -> hi=lo=0xFFFFFFFF. `ex_stall` 3 cycles each.
5. MULT with `flush` in c2 (`WAIT`) -> hi/lo unchanged, state `IDLE`, `ex_stall`=0 in c2; `ex_valid`+`flush` in `IDLE` -> no `mul_start`.
6. `cpu_rst` pulsed during `ACC` of MADD -> immediately hi=lo=0, `mul_start`=0, `ex_stall`=0. MTLO 0x1234 after release -> lo=0x1234 next cycle, no stall.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mul_ctrl_pkg
//   Shared constants for the multiply controller: datapath widths, the 4-bit
//   EX-stage operation encodings, the controller FSM state enum and small
//   decode helpers used by both the controller and anything that drives it.
// -----------------------------------------------------------------------------
package mul_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 2 * DATA_W;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    MUL_NOP = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    MUL     = 4'd3,
    MADD    = 4'd4,
    MADDU   = 4'd5,
    MSUB    = 4'd6,
    MSUBU   = 4'd7,
    MTHI    = 4'd8,
    MTLO    = 4'd9
  } ex_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACC   = 2'd3
  } state_e;

  // Operations that go through the multiplier (everything from MULT to MSUBU).
  function automatic logic is_mul_class(input logic [OP_W-1:0] op);
    return (op == MULT)  || (op == MULTU) || (op == MUL)  ||
           (op == MADD)  || (op == MADDU) || (op == MSUB) || (op == MSUBU);
  endfunction

  // Operations whose product is formed from two's-complement operands.
  function automatic logic is_signed(input logic [OP_W-1:0] op);
    return (op == MULT) || (op == MUL) || (op == MADD) || (op == MSUB);
  endfunction

  // Operations that fold the product into HI/LO instead of overwriting it.
  function automatic logic is_acc(input logic [OP_W-1:0] op);
    return (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
  endfunction

  // Accumulating operations that subtract the product.
  function automatic logic is_sub(input logic [OP_W-1:0] op);
    return (op == MSUB) || (op == MSUBU);
  endfunction

endpackage

// File: rtl/mul_hilo.sv
// -----------------------------------------------------------------------------
// mul_hilo
//   Architectural HI/LO register pair.
//   Ports:
//     clk, rst       : clock, asynchronous active-high reset (HI/LO -> 0)
//     wr_prod_en     : load {hi,lo} with wr_prod (MULT/MULTU retire)
//     wr_prod        : 64-bit product
//     wr_hi_en       : load hi with wr_data (MTHI)
//     wr_lo_en       : load lo with wr_data (MTLO)
//     wr_data        : single-register write value
//     acc_en         : {hi,lo} <= {hi,lo} +/- acc_val (MADD family)
//     acc_sub        : select subtract for the accumulate
//     acc_val        : 64-bit product to accumulate
//     hi, lo         : current register contents
//   The controller never asserts more than one write source in a cycle; the
//   priority below only makes the behaviour well defined if it ever did.
// -----------------------------------------------------------------------------
module mul_hilo
  import mul_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_prod_en,
  input  logic [PROD_W-1:0] wr_prod,
  input  logic              wr_hi_en,
  input  logic              wr_lo_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              acc_en,
  input  logic              acc_sub,
  input  logic [PROD_W-1:0] acc_val,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [PROD_W-1:0] hilo_q;
  logic [PROD_W-1:0] hilo_d;

  // Accumulate is plain 64-bit modular arithmetic: signed and unsigned
  // variants differ only in how the product was formed, not in the add.
  function automatic logic [PROD_W-1:0] acc_wrap(input logic [PROD_W-1:0] base,
                                                 input logic [PROD_W-1:0] val,
                                                 input logic              sub);
    logic [PROD_W-1:0] res;
    if (sub) res = base - val;
    else     res = base + val;
    return res;
  endfunction

  always_comb begin
    hilo_d = hilo_q;
    if (wr_prod_en) begin
      hilo_d = wr_prod;
    end else if (acc_en) begin
      hilo_d = acc_wrap(hilo_q, acc_val, acc_sub);
    end else begin
      if (wr_hi_en) hilo_d[PROD_W-1:DATA_W] = wr_data;
      if (wr_lo_en) hilo_d[DATA_W-1:0]      = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hilo_q <= '0;
    end else begin
      hilo_q <= hilo_d;
    end
  end

  assign hi = hilo_q[PROD_W-1:DATA_W];
  assign lo = hilo_q[DATA_W-1:0];

endmodule

// File: rtl/mul_ctrl.sv
// -----------------------------------------------------------------------------
// mul_ctrl
//   Sequencing controller between the EX stage and a one-cycle multiplier
//   (mul_alu, instantiated by the parent). Decodes multiply-class ops, drives
//   the multiplier start/operand/sign inputs, owns HI/LO (including
//   MADD/MSUB accumulation) and stalls EX until each operation retires.
//   Ports:
//     cpu_clk, cpu_rst   : clock, asynchronous active-high reset
//     ex_valid, ex_op    : EX-stage instruction valid and operation code
//     ex_src1, ex_src2   : rs / rt operands
//     flush              : abort the current operation (highest priority)
//     ex_stall           : hold the EX stage (combinational)
//     res_valid,res_data : MUL GPR result strobe and low 32 bits of product
//     hi, lo             : architectural HI/LO
//     mul_start          : one-cycle multiplier start (registered)
//     mul_reg1, mul_reg2 : multiplier operands (registered, held until next accept)
//     mul_signed         : multiplier signed_op (registered)
//     mul_done           : multiplier done
//     mul_result         : multiplier 64-bit product
// -----------------------------------------------------------------------------
module mul_ctrl
  import mul_ctrl_pkg::*;
(
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              ex_valid,
  input  logic [OP_W-1:0]   ex_op,
  input  logic [DATA_W-1:0] ex_src1,
  input  logic [DATA_W-1:0] ex_src2,
  input  logic              flush,
  output logic              ex_stall,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_reg1,
  output logic [DATA_W-1:0] mul_reg2,
  output logic              mul_signed,
  input  logic              mul_done,
  input  logic [PROD_W-1:0] mul_result
);

  state_e            state_q,  state_d;
  logic [OP_W-1:0]   op_q,     op_d;
  logic [DATA_W-1:0] reg1_q,   reg1_d;
  logic [DATA_W-1:0] reg2_q,   reg2_d;
  logic              signed_q, signed_d;
  logic              start_q,  start_d;
  logic [PROD_W-1:0] prod_q,   prod_d;

  logic              accept;
  logic              stall_raw;
  logic              res_valid_raw;
  logic              wr_prod_en;
  logic              wr_hi_en;
  logic              wr_lo_en;
  logic              acc_en;

  assign accept = ex_valid && !flush;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    reg1_d        = reg1_q;
    reg2_d        = reg2_q;
    signed_d      = signed_q;
    start_d       = 1'b0;
    prod_d        = prod_q;
    stall_raw     = 1'b0;
    res_valid_raw = 1'b0;
    wr_prod_en    = 1'b0;
    wr_hi_en      = 1'b0;
    wr_lo_en      = 1'b0;
    acc_en        = 1'b0;

    case (state_q)
      IDLE: begin
        // A late mul_done from a flushed operation lands here and is ignored.
        if (accept) begin
          if (is_mul_class(ex_op)) begin
            state_d   = ISSUE;
            op_d      = ex_op;
            reg1_d    = ex_src1;
            reg2_d    = ex_src2;
            signed_d  = is_signed(ex_op);
            start_d   = 1'b1;
            stall_raw = 1'b1;
          end else if (ex_op == MTHI) begin
            wr_hi_en  = 1'b1;
          end else if (ex_op == MTLO) begin
            wr_lo_en  = 1'b1;
          end
        end
      end

      ISSUE: begin
        // mul_start is already registered high for this cycle; a flush here
        // cannot retract it, so the resulting done simply arrives in IDLE.
        if (flush) begin
          state_d   = IDLE;
        end else begin
          state_d   = WAIT;
          stall_raw = 1'b1;
        end
      end

      WAIT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mul_done) begin
          if (is_acc(op_q)) begin
            prod_d    = mul_result;
            state_d   = ACC;
            stall_raw = 1'b1;
          end else begin
            state_d = IDLE;
            if (op_q == MUL) res_valid_raw = 1'b1;
            else             wr_prod_en    = 1'b1;
          end
        end else begin
          stall_raw = 1'b1;
        end
      end

      ACC: begin
        state_d = IDLE;
        if (!flush) acc_en = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q  <= IDLE;
      op_q     <= MUL_NOP;
      reg1_q   <= '0;
      reg2_q   <= '0;
      signed_q <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      reg1_q   <= reg1_d;
      reg2_q   <= reg2_d;
      signed_q <= signed_d;
      start_q  <= start_d;
    end
  end

  // Product holding register between WAIT and ACC; pure data, only read in
  // ACC after being loaded, so it needs no reset.
  always_ff @(posedge cpu_clk) begin
    prod_q <= prod_d;
  end

  mul_hilo u_hilo (
    .clk        (cpu_clk),
    .rst        (cpu_rst),
    .wr_prod_en (wr_prod_en),
    .wr_prod    (mul_result),
    .wr_hi_en   (wr_hi_en),
    .wr_lo_en   (wr_lo_en),
    .wr_data    (ex_src1),
    .acc_en     (acc_en),
    .acc_sub    (is_sub(op_q)),
    .acc_val    (prod_q),
    .hi         (hi),
    .lo         (lo)
  );

  // Combinational outputs are forced low while reset is held.
  assign ex_stall   = stall_raw && !cpu_rst;
  assign res_valid  = res_valid_raw && !cpu_rst;
  assign res_data   = res_valid ? mul_result[DATA_W-1:0] : '0;

  assign mul_start  = start_q;
  assign mul_reg1   = reg1_q;
  assign mul_reg2   = reg2_q;
  assign mul_signed = signed_q;

endmodule

// File: tb/tb_mul_ctrl.sv
module tb_mul_ctrl;
  import mul_ctrl_pkg::*;

  localparam int NOFL = 99;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [31:0] ex_src1;
  logic [31:0] ex_src2;
  logic        flush;
  logic        ex_stall;
  logic        res_valid;
  logic [31:0] res_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mul_start;
  logic [31:0] mul_reg1;
  logic [31:0] mul_reg2;
  logic        mul_signed;
  logic        mul_done;
  logic [63:0] mul_result;

  int checks = 0;
  int errors = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  always #5 cpu_clk = ~cpu_clk;

  mul_ctrl dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .ex_valid   (ex_valid),
    .ex_op      (ex_op),
    .ex_src1    (ex_src1),
    .ex_src2    (ex_src2),
    .flush      (flush),
    .ex_stall   (ex_stall),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .hi         (hi),
    .lo         (lo),
    .mul_start  (mul_start),
    .mul_reg1   (mul_reg1),
    .mul_reg2   (mul_reg2),
    .mul_signed (mul_signed),
    .mul_done   (mul_done),
    .mul_result (mul_result)
  );

  // Exact product: sign-extend to 64 bits when signed, multiply modulo 2^64.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{s & a[31]}}, a};
    eb = {{32{s & b[31]}}, b};
    return ea * eb;
  endfunction

  // Behavioural one-cycle multiplier standing in for mul_alu.
  always @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      mul_done   <= 1'b0;
      mul_result <= '0;
    end else begin
      mul_done   <= mul_start;
      mul_result <= ref_prod(mul_reg1, mul_reg2, mul_signed);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one instruction through EX and check every cycle against the
  // architectural rules. flush_k is the cycle (0 = accept cycle) in which
  // flush is raised; NOFL means never.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_k);
    logic        mc;
    logic        s;
    logic        commit;
    logic [63:0] p;
    logic [63:0] hl_old;
    logic [63:0] hl_new;
    logic [63:0] hl_exp;
    int          nstall;
    int          last;
    mc = (op == MULT) || (op == MULTU) || (op == MUL) || (op == MADD) ||
         (op == MADDU) || (op == MSUB) || (op == MSUBU);
    s  = (op == MULT) || (op == MUL) || (op == MADD) || (op == MSUB);
    p  = ref_prod(a, b, s);
    hl_old = {hi_m, lo_m};
    hl_new = hl_old;
    nstall = 0;
    case (op)
      MULT, MULTU:  begin hl_new = p;          nstall = 2; end
      MUL:          begin                      nstall = 2; end
      MADD, MADDU:  begin hl_new = hl_old + p; nstall = 3; end
      MSUB, MSUBU:  begin hl_new = hl_old - p; nstall = 3; end
      MTHI:         hl_new[63:32] = a;
      MTLO:         hl_new[31:0]  = a;
      default:      ;
    endcase
    commit = flush_k > nstall;
    last   = (nstall < 2) ? 3 : nstall + 1;
    for (int k = 0; k <= last; k++) begin
      ex_valid = (k <= nstall) && (k <= flush_k);
      ex_op    = op;
      ex_src1  = a;
      ex_src2  = b;
      flush    = (k == flush_k);
      #1;
      chk($sformatf("op%0d_k%0d_stall", op, k), 64'(ex_stall),
          64'((k < nstall) && (k < flush_k)));
      chk($sformatf("op%0d_k%0d_start", op, k), 64'(mul_start),
          64'(mc && (k == 1) && (flush_k > 0)));
      chk($sformatf("op%0d_k%0d_rvalid", op, k), 64'(res_valid),
          64'((op == MUL) && (k == 2) && (flush_k > 2)));
      chk($sformatf("op%0d_k%0d_rdata", op, k), 64'(res_data),
          ((op == MUL) && (k == 2) && (flush_k > 2)) ? 64'(p[31:0]) : 64'd0);
      hl_exp = (commit && (k > nstall)) ? hl_new : hl_old;
      chk($sformatf("op%0d_k%0d_hilo", op, k), {hi, lo}, hl_exp);
      if (mc && (k == 1) && (flush_k > 0)) begin
        chk($sformatf("op%0d_reg1", op), 64'(mul_reg1), 64'(a));
        chk($sformatf("op%0d_reg2", op), 64'(mul_reg2), 64'(b));
        chk($sformatf("op%0d_sign", op), 64'(mul_signed), 64'(s));
      end
      @(negedge cpu_clk);
    end
    ex_valid = 1'b0;
    flush    = 1'b0;
    if (commit) {hi_m, lo_m} = hl_new;
  endtask

  logic [31:0] corners [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          rfk;

    cpu_rst  = 1'b1;
    ex_valid = 1'b0;
    ex_op    = MUL_NOP;
    ex_src1  = '0;
    ex_src2  = '0;
    flush    = 1'b0;
    hi_m     = '0;
    lo_m     = '0;
    repeat (2) @(negedge cpu_clk);

    // Reset state
    chk("rst_stall",  64'(ex_stall),   64'd0);
    chk("rst_rvalid", 64'(res_valid),  64'd0);
    chk("rst_rdata",  64'(res_data),   64'd0);
    chk("rst_hilo",   {hi, lo},        64'd0);
    chk("rst_start",  64'(mul_start),  64'd0);
    chk("rst_regs",   {mul_reg1, mul_reg2}, 64'd0);
    chk("rst_sign",   64'(mul_signed), 64'd0);
    cpu_rst = 1'b0;
    @(negedge cpu_clk);

    // 1: signed MULT
    run_op(MULT, 32'hFFFF_FFFE, 32'd3, NOFL);
    chk("t1_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("t1_lo", 64'(lo), 64'hFFFF_FFFA);

    // 2: unsigned MULTU, same operands
    run_op(MULTU, 32'hFFFF_FFFE, 32'd3, NOFL);
    chk("t2_hi", 64'(hi), 64'h0000_0002);
    chk("t2_lo", 64'(lo), 64'hFFFF_FFFA);
    chk("t2_sign_held", 64'(mul_signed), 64'd0);

    // 3: MUL leaves HI/LO alone
    run_op(MTHI, 32'h11, 32'h0, NOFL);
    run_op(MTLO, 32'h22, 32'h0, NOFL);
    run_op(MUL, 32'd7, 32'd6, NOFL);
    chk("t3_hi", 64'(hi), 64'h11);
    chk("t3_lo", 64'(lo), 64'h22);

    // 4: accumulate carry and borrow across the HI/LO boundary
    run_op(MTHI, 32'h0, 32'h0, NOFL);
    run_op(MTLO, 32'hFFFF_FFFF, 32'h0, NOFL);
    run_op(MADD, 32'd1, 32'd1, NOFL);
    chk("t4_madd_hi", 64'(hi), 64'h1);
    chk("t4_madd_lo", 64'(lo), 64'h0);
    run_op(MTHI, 32'h0, 32'h0, NOFL);
    run_op(MTLO, 32'h0, 32'h0, NOFL);
    run_op(MSUBU, 32'd1, 32'd1, NOFL);
    chk("t4_msubu_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("t4_msubu_lo", 64'(lo), 64'hFFFF_FFFF);

    // 5: flushes in WAIT, IDLE, ISSUE and ACC
    run_op(MTHI, 32'hAAAA, 32'h0, NOFL);
    run_op(MTLO, 32'h5555, 32'h0, NOFL);
    run_op(MULT, 32'd5, 32'd7, 2);
    chk("t5_hi", 64'(hi), 64'hAAAA);
    chk("t5_lo", 64'(lo), 64'h5555);
    run_op(MULT, 32'd9, 32'd9, 0);
    run_op(MADD, 32'd3, 32'd3, 1);
    run_op(MUL, 32'd3, 32'd5, 2);
    run_op(MSUB, 32'd4, 32'd4, 3);
    run_op(MTLO, 32'hBEEF, 32'h0, 0);
    chk("t5_after_hi", 64'(hi), 64'hAAAA);
    chk("t5_after_lo", 64'(lo), 64'h5555);
    run_op(MULTU, 32'd10, 32'd10, NOFL);
    chk("t5_recover_lo", 64'(lo), 64'd100);

    // 6: reset while in ACC of a MADD
    run_op(MTHI, 32'h77, 32'h0, NOFL);
    ex_op   = MADD;
    ex_src1 = 32'd3;
    ex_src2 = 32'd4;
    for (int k = 0; k < 3; k++) begin
      ex_valid = 1'b1;
      @(negedge cpu_clk);
    end
    ex_valid = 1'b0;
    #1;
    chk("t6_pre_hi", 64'(hi), 64'h77);
    cpu_rst = 1'b1;
    #1;
    chk("t6_rst_hilo",  {hi, lo},       64'd0);
    chk("t6_rst_start", 64'(mul_start), 64'd0);
    chk("t6_rst_stall", 64'(ex_stall),  64'd0);
    chk("t6_rst_rval",  64'(res_valid), 64'd0);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    hi_m    = '0;
    lo_m    = '0;
    @(negedge cpu_clk);
    chk("t6_post_hilo", {hi, lo}, 64'd0);
    run_op(MTLO, 32'h1234, 32'h0, NOFL);
    chk("t6_mtlo", 64'(lo), 64'h1234);

    // Randomized ops, operands and occasional flushes
    for (int i = 0; i < 80; i++) begin
      rop = 4'($urandom_range(0, 9));
      ra  = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
      rb  = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
      rfk = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : NOFL;
      run_op(rop, ra, rb, rfk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
